// File: rtl/cache_line_unpacker_if.sv
// rtl/cache_line_unpacker_if.sv - line-in / word-out handshake bundle for the cache line unpacker
interface cache_line_unpacker_if #(
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 8,
    parameter int CNT_W          = 16
);
    localparam int LINE_W = WORD_W * WORDS_PER_LINE;
    localparam int IDX_W  = $clog2(WORDS_PER_LINE);

    logic              in_valid;
    logic              in_ready;
    logic [LINE_W-1:0] line_in;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] word_out;
    logic [IDX_W-1:0]  word_idx;
    logic              word_last;
    logic [CNT_W-1:0]  lines_done;

    // Line source and word consumer side
    modport master (
        output in_valid, line_in, out_ready,
        input  in_ready, out_valid, word_out, word_idx, word_last, lines_done
    );

    // Unpacker side
    modport slave (
        input  in_valid, line_in, out_ready,
        output in_ready, out_valid, word_out, word_idx, word_last, lines_done
    );
endinterface

// File: rtl/cache_line_unpacker.sv
// rtl/cache_line_unpacker.sv - splits 256-bit cache lines into a 32-bit word stream, MSW first
module cache_line_unpacker #(
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 8,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cache_line_unpacker_if.slave  bus
);
    localparam int LINE_W = WORD_W * WORDS_PER_LINE;
    localparam int IDX_W  = $clog2(WORDS_PER_LINE);

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [LINE_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic out_valid;
    logic is_last;
    logic xfer;
    logic in_ready;
    logic accept;

    // Handshake decode and next-state: a last-word transfer frees the slot in the
    // same cycle so a new line can load without a bubble.
    always_comb begin
        out_valid = (state_q == DRAIN);
        is_last   = out_valid && (idx_q == IDX_W'(WORDS_PER_LINE - 1));
        xfer      = out_valid && bus.out_ready;
        in_ready  = (state_q == EMPTY) || (xfer && is_last);
        accept    = bus.in_valid && in_ready;

        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;

        if (xfer) begin
            if (is_last) begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = EMPTY;
            end else begin
                shreg_d = {shreg_q[LINE_W-WORD_W-1:0], {WORD_W{1'b0}}};
                idx_d   = idx_q + IDX_W'(1);
            end
        end

        if (accept) begin
            shreg_d = bus.line_in;
            idx_d   = '0;
            state_d = DRAIN;
        end
    end

    // State, shift register, word index and line counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            shreg_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.word_out   = shreg_q[LINE_W-1 -: WORD_W];
    assign bus.word_idx   = idx_q;
    assign bus.word_last  = is_last;
    assign bus.lines_done = cnt_q;
endmodule

// File: tb/tb_cache_line_unpacker.sv
// tb/tb_cache_line_unpacker.sv - self-checking bench for cache_line_unpacker
module tb_cache_line_unpacker;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cache_line_unpacker_if #(.WORD_W(32), .WORDS_PER_LINE(8), .CNT_W(16)) bus ();
    cache_line_unpacker_if #(.WORD_W(32), .WORDS_PER_LINE(8), .CNT_W(2))  bus2 ();

    cache_line_unpacker #(.WORD_W(32), .WORDS_PER_LINE(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cache_line_unpacker #(.WORD_W(32), .WORDS_PER_LINE(8), .CNT_W(2)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.line_in   = bus.line_in;
    assign bus2.out_ready = bus.out_ready;

    int tests = 0;
    int fails = 0;

    logic [255:0] src_q[$];
    logic [31:0]  exp_q[$];
    int           lines_cnt;
    int           mode;
    bit           src_en;
    bit           phase;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit m_valid;
        m_valid = (exp_q.size() > 0);
        chk("out_valid", 256'(bus.out_valid), 256'(m_valid));
        chk("in_ready", 256'(bus.in_ready),
            256'((exp_q.size() == 0) || (bus.out_ready && exp_q.size() == 1)));
        chk("word_last", 256'(bus.word_last), 256'(m_valid && exp_q.size() == 1));
        chk("lines_done", 256'(bus.lines_done), 256'(lines_cnt % 65536));
        chk("lines_done_w2", 256'(bus2.lines_done), 256'(lines_cnt % 4));
        if (m_valid) begin
            chk("word_out", 256'(bus.word_out), 256'(exp_q[0]));
            chk("word_idx", 256'(bus.word_idx), 256'(8 - exp_q.size()));
        end
    endtask

    // One clock cycle: drive inputs, check against the queue model, advance the model.
    task automatic cycle();
        bit m_ready, m_acc, m_xfer;
        logic [255:0] ln;
        bus.in_valid  = src_en && (src_q.size() > 0);
        bus.line_in   = (src_q.size() > 0) ? src_q[0] : 256'd0;
        case (mode)
            0:       bus.out_ready = 1'b1;
            1:       begin bus.out_ready = ~phase; phase = ~phase; end
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        check_outputs();
        m_ready = (exp_q.size() == 0) || (bus.out_ready && exp_q.size() == 1);
        m_acc   = bus.in_valid && m_ready;
        m_xfer  = (exp_q.size() > 0) && bus.out_ready;
        ln      = bus.line_in;
        @(posedge clk);
        if (m_xfer) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) lines_cnt++;
        end
        if (m_acc) begin
            for (int k = 0; k < 8; k++) exp_q.push_back(ln[255 - 32*k -: 32]);
            void'(src_q.pop_front());
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready", 256'(bus.in_ready), 256'(1));
        chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
        chk("rst_word_out", 256'(bus.word_out), 256'(0));
        chk("rst_word_idx", 256'(bus.word_idx), 256'(0));
        chk("rst_word_last", 256'(bus.word_last), 256'(0));
        chk("rst_lines_done", 256'(bus.lines_done), 256'(0));
        chk("rst_lines_done_w2", 256'(bus2.lines_done), 256'(0));
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom();
        return l;
    endfunction

    initial begin
        logic [255:0] fixed;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.line_in   = '0;
        bus.out_ready = 1'b0;
        lines_cnt     = 0;
        mode          = 0;
        src_en        = 1'b1;
        phase         = 1'b0;
        #3;
        check_reset_values();
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single known line, then idle source
        for (int k = 0; k < 8; k++) fixed[255 - 32*k -: 32] = 32'h1111_1111 * k;
        src_q.push_back(fixed);
        run(11);
        chk("single_lines_done", 256'(bus.lines_done), 256'(1));

        // Back-to-back random lines
        for (int i = 0; i < 3; i++) src_q.push_back(rand_line());
        run(27);
        chk("b2b_lines_done", 256'(bus.lines_done), 256'(4));

        // Alternating backpressure on one line
        mode = 1;
        src_q.push_back(rand_line());
        run(20);
        mode = 0;
        run(2);

        // Reset after word 3 transfers
        src_q.push_back(rand_line());
        run(5);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        src_q.delete();
        lines_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        src_q.push_back(rand_line());
        run(10);

        // Random source gaps and random backpressure, wraps the narrow counter
        mode = 2;
        for (int i = 0; i < 12; i++) src_q.push_back(rand_line());
        for (int c = 0; c < 400 && (src_q.size() > 0 || exp_q.size() > 0); c++) begin
            src_en = ($urandom_range(0, 3) != 0);
            cycle();
        end
        src_en = 1'b1;
        chk("drained", 256'(src_q.size() + exp_q.size()), 256'(0));
        chk("final_lines_done", 256'(bus.lines_done), 256'(13));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cache_line_unpacker.md
# cache_line_unpacker

Converts 256-bit cache lines back into the 32-bit word stream they were packed from. It is the inverse of the trace packer, which places the first word of each line in bits [255:224]. The block sits between a line source (memory model or decompressor output) and any consumer of 32-bit trace words. Both sides use valid/ready handshakes, and the block sustains one word per cycle across line boundaries.

## Interface
- WORD_W, 32, width of one trace word
- WORDS_PER_LINE, 8, words per cache line; line width = WORD_W*WORDS_PER_LINE (256)
- CNT_W, 16, width of the lines-completed counter

- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset; clears all state immediately
- in_valid  input  1  line_in is valid
- in_ready  output  1  block can accept a line this cycle
- line_in  input  256  packed line; word 0 = [255:224], word 7 = [31:0]
- out_valid  output  1  word_out is valid
- out_ready  input  1  consumer accepts word_out this cycle
- word_out  output  32  current word
- word_idx  output  3  index (0..7) of word_out within its line
- word_last  output  1  high when word_idx == WORDS_PER_LINE-1 and out_valid
- lines_done  output  CNT_W  count of lines fully emitted, wraps modulo 2^CNT_W

## Operation
- Two states: EMPTY (no line held) and DRAIN (line held in a 256-bit shift register, emitting words).
- in_ready = (state==EMPTY) | (out_valid & out_ready & word_last).
- A line is accepted when in_valid & in_ready. The accepted line loads the shift register, word_idx is set to 0, and the state becomes DRAIN.
- word_out is always bits [255:224] of the shift register. word_out is meaningful only while out_valid is high.
- out_valid = (state==DRAIN).
- Word transfer (out_valid & out_ready) on a non-last word:
  - shift register shifts left by WORD_W, zero-filled from the bottom;
  - word_idx increments by 1.
- Word transfer on the last word:
  - lines_done increments by 1;
  - if a new line is accepted in the same cycle, the new line loads, word_idx becomes 0, and the state stays DRAIN (no bubble);
  - otherwise the state becomes EMPTY.
- With out_ready low, word_out, word_idx and the shift register hold. in_ready stays low while a line is held and not on its last-word transfer.
- in_valid without in_ready has no effect. The source must hold line_in stable until it is accepted.
- lines_done wraps from 2^CNT_W-1 to 0 with no flag.
- Zero-valued words are emitted like any other word. The block does not skip or compress them.

## Timing
- Reset values (asynchronous, take effect while rst_n is low):
  - state = EMPTY;
  - in_ready = 1 (combinational from state);
  - out_valid = 0, word_out = 0, word_idx = 0, word_last = 0, lines_done = 0.
- Latency: a line accepted on edge N presents word 0 on out_valid after edge N. Word k appears after edge N+k when out_ready is held high.
- Throughput: 8 cycles per line, back-to-back, with out_ready and in_valid continuously high.
- Reset asserted mid-line: the held line is discarded and the partial count is not added. After release, the first accepted line starts at word_idx 0.
- All outputs are registered except in_ready, out_valid and word_last, which are decoded from registered state.

## Test plan
- Single line: after reset, send line_in = 0x00000000_11111111_22222222_…_77777777 with out_ready=1 -> words 0x00000000..0x77777777 appear on 8 consecutive cycles with word_idx 0..7. word_last is high only with 0x77777777. lines_done = 1 and out_valid = 0 afterwards.
- Back-to-back: with in_valid held high, send three distinct lines -> 24 consecutive out_valid cycles with no gap. in_ready is high only on each last-word cycle. lines_done = 3.
- Backpressure: toggle out_ready every cycle (1,0,1,0…) on one line -> each word is held for at least 2 cycles. Order and values are unchanged, and in_ready stays 0 until the word-7 transfer.
- Idle source: deassert in_valid after one line -> out_valid = 0 and the state is EMPTY after word 7. A later line starts again at word_idx 0.
- Reset mid-line: assert rst_n=0 after word 3 is transferred -> outputs immediately go to their reset values and lines_done = 0. The next line is emitted starting at word 0.
- Counter wrap (CNT_W=2): emit 5 lines -> lines_done reads 1,2,3,0,1.
